// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the registered 1-to-N stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/demux_lane_gate.sv
// Expands one registered beat (valid/dest/data/last) into N zero-gated output lanes.
module demux_lane_gate #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          vld,
  input  logic [SW-1:0] dest,
  input  logic [W-1:0]  data,
  input  logic          last,
  output logic [N*W-1:0] lane_data,
  output logic [N-1:0]   lane_valid,
  output logic [N-1:0]   lane_last
);

  always_comb begin
    lane_data  = '0;
    lane_valid = '0;
    lane_last  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vld && dest == SW'(i)) begin
        lane_valid[i]       = 1'b1;
        lane_last[i]        = last;
        lane_data[i*W +: W] = data;
      end
    end
  end

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N packet demux with valid/ready handshake and per-packet destination lock.
// Optional per-channel packet / dropped-packet counters when STREAM_DEMUX_CNT_EN is defined.
module stream_demux_1ton
  import stream_demux_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   s_data,
  input  logic           s_valid,
  input  logic           s_last,
  output logic           s_ready,
  input  logic [SW-1:0]  sel,
  output logic [N*W-1:0] m_data,
  output logic [N-1:0]   m_valid,
  output logic [N-1:0]   m_last,
  input  logic [N-1:0]   m_ready,
  output logic           err
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [N*CNT_W-1:0] cnt_pkt,
  output logic [CNT_W-1:0]   cnt_drop
`endif
);

  state_t        state;
  logic [SW-1:0] dest;
  logic          out_vld;
  logic [SW-1:0] out_dest;
  logic [W-1:0]  out_data;
  logic          out_last;

  logic          dest_ready;
  logic          s_xfer;
  logic          drain;
  logic          sel_ok;

  // Only the held beat's own channel can free the register; other m_ready bits are ignored.
  always_comb begin
    dest_ready = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (out_dest == SW'(i)) dest_ready = m_ready[i];
    end
  end

  assign s_ready = !out_vld || dest_ready;
  assign s_xfer  = s_valid && s_ready;
  assign drain   = out_vld && dest_ready;
  assign sel_ok  = 32'(sel) < 32'(N);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dest     <= '0;
      out_vld  <= 1'b0;
      out_dest <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (s_xfer) begin
        out_data <= s_data;
        out_last <= s_last;
        case (state)
          IDLE: begin
            if (sel_ok) begin
              dest     <= sel;
              out_dest <= sel;
              out_vld  <= 1'b1;
              state    <= s_last ? IDLE : PASS;
            end else begin
              err     <= 1'b1;
              out_vld <= 1'b0;
              state   <= s_last ? IDLE : DROP;
            end
          end
          PASS: begin
            out_dest <= dest;
            out_vld  <= 1'b1;
            if (s_last) state <= IDLE;
          end
          DROP: begin
            out_vld <= 1'b0;
            if (s_last) state <= IDLE;
          end
          default: begin
            out_vld <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end else if (drain) begin
        out_vld <= 1'b0;
      end
    end
  end

  demux_lane_gate #(
    .N (N),
    .W (W),
    .SW(SW)
  ) u_lane_gate (
    .vld       (out_vld),
    .dest      (out_dest),
    .data      (out_data),
    .last      (out_last),
    .lane_data (m_data),
    .lane_valid(m_valid),
    .lane_last (m_last)
  );

`ifdef STREAM_DEMUX_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_pkt  <= '0;
      cnt_drop <= '0;
    end else begin
      if (s_xfer && state == IDLE && !sel_ok) cnt_drop <= cnt_drop + CNT_W'(1);
      for (int unsigned i = 0; i < N; i++) begin
        if (drain && out_last && out_dest == SW'(i))
          cnt_pkt[i*CNT_W +: CNT_W] <= cnt_pkt[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Directed bench: an N=8 and an N=6 demux share one stimulus stream; N=6 exercises sel >= N.
module tb_stream_demux_1ton;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [2:0]  sel = '0;
  logic [7:0]  m_ready = '1;

  logic        s_ready8, err8, s_ready6, err6;
  logic [63:0] m_data8;
  logic [7:0]  m_valid8, m_last8;
  logic [47:0] m_data6;
  logic [5:0]  m_valid6, m_last6;
`ifdef STREAM_DEMUX_CNT_EN
  logic [127:0] cnt_pkt8;
  logic [95:0]  cnt_pkt6;
  logic [15:0]  cnt_drop8, cnt_drop6;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stream_demux_1ton #(.N(8), .W(W)) dut8 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready8), .sel(sel), .m_data(m_data8), .m_valid(m_valid8),
    .m_last(m_last8), .m_ready(m_ready), .err(err8)
`ifdef STREAM_DEMUX_CNT_EN
    , .cnt_pkt(cnt_pkt8), .cnt_drop(cnt_drop8)
`endif
  );

  stream_demux_1ton #(.N(6), .W(W)) dut6 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready6), .sel(sel), .m_data(m_data6), .m_valid(m_valid6),
    .m_last(m_last6), .m_ready(m_ready[5:0]), .err(err6)
`ifdef STREAM_DEMUX_CNT_EN
    , .cnt_pkt(cnt_pkt6), .cnt_drop(cnt_drop6)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one beat, let one edge pass, then drop s_valid; outputs are sampled 1 time unit later.
  task automatic send(input logic [2:0] s, input logic [7:0] d, input logic l);
    sel = s; s_data = d; s_last = l; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    do_reset();
    check("rst_m_valid8", m_valid8, 8'h00);
    check("rst_m_data8",  m_data8, 64'h0);
    check("rst_err8",     err8, 1'b0);
    check("rst_s_ready8", s_ready8, 1'b1);
    check("rst_m_valid6", m_valid6, 6'h00);

    // Single-beat packet to lane 3
    send(3'd3, 8'hA5, 1'b1);
    check("one_valid8", m_valid8, 8'h08);
    check("one_data8",  m_data8, 64'h0000_0000_A500_0000);
    check("one_last8",  m_last8, 8'h08);
    check("one_valid6", m_valid6, 6'h08);
    check("one_data6",  m_data6, 48'h0000_A500_0000);
    idle();
    check("one_drain8", m_valid8, 8'h00);

    // 4-beat packet locked to lane 5 despite sel moving to 2
    send(3'd5, 8'h10, 1'b0);
    check("lock0_valid", m_valid8, 8'h20);
    check("lock0_data",  m_data8[40 +: 8], 8'h10);
    check("lock0_last",  m_last8, 8'h00);
    send(3'd2, 8'h11, 1'b0);
    check("lock1_valid", m_valid8, 8'h20);
    check("lock1_data",  m_data8[40 +: 8], 8'h11);
    send(3'd2, 8'h12, 1'b0);
    check("lock2_data",  m_data8[40 +: 8], 8'h12);
    check("lock2_valid6", m_valid6, 6'h20);
    send(3'd2, 8'h13, 1'b1);
    check("lock3_valid", m_valid8, 8'h20);
    check("lock3_data",  m_data8[40 +: 8], 8'h13);
    check("lock3_last",  m_last8, 8'h20);
    idle();
    check("lock_drain", m_valid8, 8'h00);

    // Backpressure on lane 5: held beat stays stable, next beat waits
    m_ready = 8'hDF;
    send(3'd5, 8'h20, 1'b1);
    sel = 3'd5; s_data = 8'h21; s_last = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_s_ready8", s_ready8, 1'b0);
      check("bp_data",     m_data8[40 +: 8], 8'h20);
      check("bp_valid",    m_valid8, 8'h20);
      @(posedge clk); #1;
    end
    check("bp_s_ready6", s_ready6, 1'b0);
    m_ready = 8'hFF;
    #1;
    check("bp_release_ready", s_ready8, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    check("bp_next_data",  m_data8[40 +: 8], 8'h21);
    check("bp_next_valid", m_valid8, 8'h20);
    idle();
    check("bp_empty", m_valid8, 8'h00);

    // sel = 7 is out of range for N=6 (dropped, err pulse) but valid for N=8
    send(3'd7, 8'h30, 1'b0);
    check("drop_err6",    err6, 1'b1);
    check("drop_valid6",  m_valid6, 6'h00);
    check("drop_ready6",  s_ready6, 1'b1);
    check("drop_valid8",  m_valid8, 8'h80);
    check("drop_err8",    err8, 1'b0);
    send(3'd0, 8'h31, 1'b0);
    check("drop1_err6",   err6, 1'b0);
    check("drop1_valid6", m_valid6, 6'h00);
    check("drop1_ready6", s_ready6, 1'b1);
    check("drop1_valid8", m_valid8, 8'h80);
    send(3'd0, 8'h32, 1'b1);
    check("drop2_err6",   err6, 1'b0);
    check("drop2_valid6", m_valid6, 6'h00);
    send(3'd1, 8'h33, 1'b1);
    check("after_drop_valid6", m_valid6, 6'h02);
    check("after_drop_data6",  m_data6[8 +: 8], 8'h33);
    check("after_drop_err6",   err6, 1'b0);
    check("after_drop_valid8", m_valid8, 8'h02);
    // Single-beat invalid packet followed immediately by a valid one
    send(3'd6, 8'h40, 1'b1);
    check("sb_drop_err6",   err6, 1'b1);
    check("sb_drop_valid6", m_valid6, 6'h00);
    send(3'd2, 8'h41, 1'b1);
    check("b2b_valid6", m_valid6, 6'h04);
    check("b2b_err6",   err6, 1'b0);
    check("b2b_data6",  m_data6[16 +: 8], 8'h41);
    idle();

    // Reset in the middle of a packet to lane 4
    send(3'd4, 8'h50, 1'b0);
    check("mid0_valid", m_valid8, 8'h10);
    send(3'd4, 8'h51, 1'b0);
    check("mid1_data", m_data8[32 +: 8], 8'h51);
    sel = 3'd4; s_data = 8'h52; s_last = 1'b0; s_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0;
    check("mid_rst_valid8", m_valid8, 8'h00);
    check("mid_rst_data8",  m_data8, 64'h0);
    check("mid_rst_ready8", s_ready8, 1'b1);
    send(3'd6, 8'h53, 1'b0);
    check("restart_valid8", m_valid8, 8'h40);
    check("restart_data8",  m_data8[48 +: 8], 8'h53);
    check("restart_err6",   err6, 1'b1);
    send(3'd1, 8'h54, 1'b1);
    check("restart_lock8", m_valid8, 8'h40);
    check("restart_last8", m_last8, 8'h40);
    check("restart_drop6", m_valid6, 6'h00);
    idle();

`ifdef STREAM_DEMUX_CNT_EN
    do_reset();
    check("cnt_rst_pkt8",  cnt_pkt8[63:0], 64'h0);
    check("cnt_rst_drop6", cnt_drop6, 16'h0);
    for (int i = 0; i < 3; i++) send(3'd0, 8'h60, 1'b1);
    send(3'd7, 8'h61, 1'b0);
    send(3'd7, 8'h62, 1'b1);
    idle();
    check("cnt_pkt6_l0",  cnt_pkt6[15:0], 16'd3);
    check("cnt_drop6",    cnt_drop6, 16'd1);
    check("cnt_pkt8_l0",  cnt_pkt8[15:0], 16'd3);
    check("cnt_pkt8_l7",  cnt_pkt8[127:112], 16'd1);
    check("cnt_drop8",    cnt_drop8, 16'd0);
    for (int i = 0; i < 65535; i++) send(3'd2, 8'h70, 1'b1);
    idle();
    check("cnt_top8", cnt_pkt8[47:32], 16'hFFFF);
    send(3'd2, 8'h71, 1'b1);
    idle();
    check("cnt_wrap8", cnt_pkt8[47:32], 16'h0000);
    check("cnt_wrap6", cnt_pkt6[47:32], 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1ton

Overview:
- Registered 1-to-N stream demultiplexer with valid/ready handshake and packet-level destination lock.
- Parametrised, clocked successor to the team's combinational 1-to-8 demux.
- Routes each packet from one upstream stream to one of N downstream channels, selected on the packet's first beat.
- Sits between a single packet source and N per-channel consumers. Provides backpressure and one output register stage.

Parameters:
- N, 8, number of output channels (2..16, not necessarily a power of 2).
- W, 8, data width in bits.
- SW, $clog2(N), select width (derived; not for override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  W  upstream beat data.
- s_valid  in  1  upstream beat valid.
- s_last  in  1  marks final beat of packet.
- s_ready  out  1  upstream may transfer.
- sel  in  SW  destination channel; sampled only on the first beat of a packet.
- m_data  out  N*W  lane i = bits [i*W +: W]; zero on unselected lanes.
- m_valid  out  N  per-channel valid; at most one bit set.
- m_last  out  N  per-channel last; qualified by m_valid.
- m_ready  in  N  per-channel ready.
- err  out  1  one-cycle pulse: packet start with sel >= N.

Behaviour:
- Transfer rules:
  - Upstream transfer when s_valid && s_ready.
  - Channel i transfer when m_valid[i] && m_ready[i].
- Reset (rst high at a clk edge):
  - State = IDLE.
  - Output register empty: m_valid = 0, m_last = 0, m_data = 0.
  - err = 0, dest = 0.
  - s_ready = 1 in the first cycle after reset.
  - Reset mid-packet discards the held beat and the lock. The next accepted beat is treated as a packet start.
- Output register:
  - Holds out_vld, out_dest, out_data, out_last.
  - m_valid[i] = out_vld && out_dest == i.
  - m_data lane out_dest = out_data; all other lanes 0.
  - m_last follows the same rule.
- s_ready = !out_vld || m_ready[out_dest] (combinational from m_ready). Gives full throughput: one beat per cycle under continuous ready.
- Latency: an accepted beat appears on its m_* lane the next cycle.
- Register update on each clk edge:
  - Upstream transfer: load the register (out_vld = 1 unless the packet is dropped).
  - Otherwise, if the held beat drains: out_vld = 0.
  - Otherwise: hold.
  - Data is stable while m_valid && !m_ready.
- FSM states: IDLE, PASS, DROP.
  - IDLE, transfer, sel < N: dest = sel. Go to PASS, or stay IDLE if s_last.
  - IDLE, transfer, sel >= N: pulse err. Beat is accepted and discarded (out_vld = 0). Go to DROP, or stay IDLE if s_last.
  - PASS: beats go to the locked dest; sel is ignored. Return to IDLE on the transfer with s_last.
  - DROP: beats are accepted and discarded, no err. Return to IDLE on the transfer with s_last.
- Single-beat packet (s_last on first beat): routed per sel; FSM remains IDLE.
- Back-to-back packets: a new sel is honoured on the beat immediately after the s_last transfer, with no bubble.
- sel changing mid-packet has no effect.
- m_ready on unselected channels is ignored.

Optional Feature:
- Macro: STREAM_DEMUX_CNT_EN.
- Defined:
  - Adds output cnt_pkt (N*16 bits): per-channel count of completed packets, incremented on an m_last transfer.
  - Adds output cnt_drop (16 bits): count of dropped packets, incremented on the err pulse.
  - All counters wrap at 2^16 and clear on rst.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Package stream_demux_pkg:
  - FSM state encoding (IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2).
  - Counter width constant CNT_W = 16.
- Sub-module demux_lane_gate (combinational): expands out_vld/out_dest/out_data/out_last into the N lanes, zero-gated. It is reusable by the existing demux users.
- FSM and output register stay in the top module.

Test Plan:
- Reset, then sel = 3, send one-beat packet s_data = 8'hA5, s_last = 1, all m_ready = 1 -> next cycle m_valid = 8'b0000_1000, lane 3 = 8'hA5, m_last[3] = 1, all other lanes 0.
- 4-beat packet 8'h10..8'h13, sel = 5 on beat 0, sel changed to 2 on beats 1-3 -> all four beats appear on lane 5 on consecutive cycles, m_last[5] on 8'h13, lane 2 never valid.
- Hold m_ready[5] = 0 for 3 cycles with a beat held -> s_ready = 0, m_data lane 5 stable. Release -> drains next edge, no beat lost or duplicated.
- N = 6 build, sel = 7, 3-beat packet -> err high for exactly 1 cycle on the first beat, s_ready = 1 throughout, m_valid stays 0. Next packet with sel = 1 is routed normally.
- Assert rst during beat 2 of a 4-beat packet to lane 4 -> m_valid = 0 next cycle. The next beat is treated as a packet start using the current sel.
- With STREAM_DEMUX_CNT_EN: send 3 packets to lane 0 and 1 invalid packet -> cnt_pkt lane 0 = 3, cnt_drop = 1. Preload near the top and send one packet -> the counter wraps 16'hFFFF -> 16'h0000.
